// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: TX FIFO feeding a start/busy/done sequencer, one-deep RX holding register.
// Define UART_IRQ_EN to add the registered irq output and the CTRL[4:3] interrupt enables.
module uart_mmio_ctrl #(
    parameter int TX_FIFO_DEPTH = 4,
    parameter int DATA_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        bus_addr,
    input  logic              bus_we,
    input  logic              bus_re,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic              tx_parity_en,
    output logic              tx_parity_odd,
    input  logic              tx_busy,
    input  logic              tx_done,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_parity_err
`ifdef UART_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ADDR_TX     = 2'd0;
    localparam logic [1:0] ADDR_RX     = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [7:0]       fifo_mem [TX_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [7:0] rx_hold;
    logic       rx_full;
    logic       rx_perr;
    logic       rx_overrun;
    logic       tx_overflow;
    logic       parity_en;
    logic       parity_odd;
`ifdef UART_IRQ_EN
    logic       rx_ie;
    logic       tx_ie;
`endif

    logic wr_tx;
    logic wr_ctrl;
    logic rd_rx;
    logic fifo_empty;
    logic fifo_full;
    logic tx_active;
    logic pop;
    logic push;
    logic load_head;
    logic clr_flags;

    logic [DATA_W-1:0] status_word;
    logic [DATA_W-1:0] ctrl_word;
    logic [DATA_W-1:0] rx_word;
    logic              unused_wdata;

    assign wr_tx      = bus_we && (bus_addr == ADDR_TX);
    assign wr_ctrl    = bus_we && (bus_addr == ADDR_CTRL);
    assign rd_rx      = bus_re && (bus_addr == ADDR_RX);
    assign clr_flags  = wr_ctrl && bus_wdata[2];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(TX_FIFO_DEPTH));
    assign tx_active  = (state_q != IDLE);

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push = wr_tx && (!fifo_full || pop);

    assign tx_parity_en  = parity_en;
    assign tx_parity_odd = parity_odd;
    assign unused_wdata  = ^bus_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_start  = 1'b0;
        pop       = 1'b0;
        load_head = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d   = LOAD;
                    load_head = 1'b1;
                end
            end
            LOAD: begin
                tx_start = 1'b1;
                pop      = 1'b1;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A done seen before busy means the whole frame already went by.
                if (tx_done) begin
                    state_d = IDLE;
                end else if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus_wdata[7:0];
        end
    end

    // Head is latched on entry to LOAD so tx_data is already valid alongside tx_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data <= '0;
        end else if (load_head) begin
            tx_data <= fifo_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_hold <= '0;
            rx_perr <= 1'b0;
            rx_full <= 1'b0;
        end else if (rx_valid && (!rx_full || rd_rx)) begin
            rx_hold <= rx_data;
            rx_perr <= rx_parity_err;
            rx_full <= 1'b1;
        end else if (rd_rx) begin
            rx_full <= 1'b0;
        end
    end

    // A new error event in the same cycle as a software clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_overrun  <= 1'b0;
            tx_overflow <= 1'b0;
        end else begin
            if (rx_valid && rx_full && !rd_rx) begin
                rx_overrun <= 1'b1;
            end else if (clr_flags) begin
                rx_overrun <= 1'b0;
            end
            if (wr_tx && !push) begin
                tx_overflow <= 1'b1;
            end else if (clr_flags) begin
                tx_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_en  <= 1'b0;
            parity_odd <= 1'b0;
        end else if (wr_ctrl) begin
            parity_en  <= bus_wdata[0];
            parity_odd <= bus_wdata[1];
        end
    end

`ifdef UART_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ie <= 1'b0;
            tx_ie <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                rx_ie <= bus_wdata[3];
                tx_ie <= bus_wdata[4];
            end
            irq <= (rx_full && rx_ie) || (fifo_empty && !tx_active && tx_ie);
        end
    end
`endif

    always_comb begin
        status_word       = '0;
        status_word[0]    = rx_full;
        status_word[1]    = fifo_empty;
        status_word[2]    = fifo_full;
        status_word[3]    = tx_active;
        status_word[4]    = rx_overrun;
        status_word[5]    = tx_overflow;
        status_word[6]    = rx_perr;
        status_word[15:8] = 8'(count);
    end

    always_comb begin
        ctrl_word    = '0;
        ctrl_word[0] = parity_en;
        ctrl_word[1] = parity_odd;
`ifdef UART_IRQ_EN
        ctrl_word[3] = rx_ie;
        ctrl_word[4] = tx_ie;
`endif
    end

    always_comb begin
        rx_word      = '0;
        rx_word[7:0] = rx_hold;
    end

    always_comb begin
        bus_rdata = '0;
        case (bus_addr)
            ADDR_RX:     bus_rdata = rx_word;
            ADDR_STATUS: bus_rdata = status_word;
            ADDR_CTRL:   bus_rdata = ctrl_word;
            default:     bus_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl: directed scenarios plus randomized bus/rx traffic
// against a queue-based reference model with an emulated tx core.
module tb_uart_mmio_ctrl;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    bus_addr = '0;
    logic          bus_we = 1'b0;
    logic          bus_re = 1'b0;
    logic [DW-1:0] bus_wdata = '0;
    logic [DW-1:0] bus_rdata;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_parity_en;
    logic          tx_parity_odd;
    logic          tx_busy = 1'b0;
    logic          tx_done = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_parity_err = 1'b0;

    uart_mmio_ctrl #(.TX_FIFO_DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_re(bus_re),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .tx_data(tx_data), .tx_start(tx_start),
        .tx_parity_en(tx_parity_en), .tx_parity_odd(tx_parity_odd),
        .tx_busy(tx_busy), .tx_done(tx_done),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_err(rx_parity_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: byte queue with the cycle each byte was written, frame timing, rx/flag state.
    logic [7:0] q[$];
    int         qcyc[$];
    int         cyc = 0;
    bit         inflight = 0;
    int         start_cyc = 0;
    int         done_cyc = 0;
    int         ready_cyc = 0;
    bit         nobusy = 0;
    bit         hold = 0;
    int         fixed_len = 0;
    logic [7:0] m_txd = '0;
    logic [1:0] m_ctrl = '0;
    logic [7:0] m_rx_hold = '0;
    bit         m_rx_full = 0;
    bit         m_perr = 0;
    bit         m_ovr = 0;
    bit         m_txovf = 0;

    logic [7:0]    sent[$];
    logic          obs_start;
    logic [7:0]    obs_txd;
    logic [DW-1:0] rd_val;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] exp_read(input logic [1:0] a);
        case (a)
            2'd1:    return {24'b0, m_rx_hold};
            2'd2:    return {16'b0, 8'(q.size()), 1'b0, m_perr, m_txovf, m_ovr, inflight,
                             q.size() == DEPTH, q.size() == 0, m_rx_full};
            2'd3:    return {30'b0, m_ctrl};
            default: return 32'h0;
        endcase
    endfunction

    // One clock cycle: check outputs against the model, drive inputs, advance the model, cross the edge.
    task automatic step(input bit we, input bit re, input logic [1:0] a, input logic [31:0] wd,
                        input bit rv = 0, input logic [7:0] rd = 8'h00, input bit rpe = 0,
                        input bit do_rst = 0);
        bit s;
        bit push_ok;
        s = !inflight && (q.size() > 0) && (cyc >= ready_cyc) && (qcyc[0] + 2 <= cyc);
        if (s) begin
            inflight  = 1;
            start_cyc = cyc;
            m_txd     = q[0];
            nobusy    = !hold && (fixed_len == 0) && ($urandom_range(0, 3) == 0);
            if (hold) done_cyc = 1 << 30;
            else if (fixed_len != 0) done_cyc = cyc + fixed_len;
            else done_cyc = cyc + $urandom_range(1, 8);
        end
        check("tx_start", tx_start, s);
        check("tx_data", tx_data, m_txd);
        check("parity_en", tx_parity_en, m_ctrl[0]);
        check("parity_odd", tx_parity_odd, m_ctrl[1]);
        obs_start = tx_start;
        obs_txd   = tx_data;
        if (tx_start === 1'b1) sent.push_back(tx_data);

        tx_busy       = inflight && (cyc > start_cyc) && (cyc < done_cyc) && !nobusy;
        tx_done       = inflight && (cyc == done_cyc);
        rst           = do_rst;
        bus_we        = we;
        bus_re        = re;
        bus_addr      = a;
        bus_wdata     = wd;
        rx_valid      = rv;
        rx_data       = rd;
        rx_parity_err = rpe;
        #1;
        rd_val = bus_rdata;
        if (re && a != 2'd0) check("bus_rdata", bus_rdata, exp_read(a));

        if (do_rst) begin
            q.delete(); qcyc.delete();
            inflight = 0; ready_cyc = 0; m_txd = '0; m_ctrl = '0;
            m_rx_hold = '0; m_rx_full = 0; m_perr = 0; m_ovr = 0; m_txovf = 0;
        end else begin
            push_ok = (q.size() < DEPTH) || s;
            if (s) begin
                void'(q.pop_front());
                void'(qcyc.pop_front());
            end
            if (we && a == 2'd0) begin
                if (push_ok) begin
                    q.push_back(wd[7:0]);
                    qcyc.push_back(cyc);
                end else m_txovf = 1;
            end
            if (we && a == 2'd3) begin
                m_ctrl = wd[1:0];
                if (wd[2]) begin
                    m_ovr = 0;
                    m_txovf = 0;
                end
            end
            if (rv) begin
                if (!m_rx_full || (re && a == 2'd1)) begin
                    m_rx_hold = rd;
                    m_perr    = rpe;
                    m_rx_full = 1;
                end else m_ovr = 1;
            end else if (re && a == 2'd1) m_rx_full = 0;
            if (inflight && cyc == done_cyc) begin
                inflight  = 0;
                ready_cyc = cyc + 2;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 2'd0, 32'h0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step(1, 0, a, d);
    endtask

    task automatic rd(input logic [1:0] a);
        step(0, 1, a, 32'h0);
    endtask

    task automatic rxp(input logic [7:0] d, input bit pe);
        step(0, 0, 2'd0, 32'h0, 1, d, pe);
    endtask

    initial begin
        logic [31:0] wd;
        int          op;

        repeat (3) @(posedge clk);
        #1;

        // Reset state
        rd(2'd2);
        check("rst_status", rd_val, 32'h0000_0002);
        check("rst_tx_start", obs_start, 1'b0);
        rd(2'd3);
        check("rst_ctrl", rd_val, 32'h0);

        // Single byte, fixed 20-cycle busy
        fixed_len = 21;
        wr(2'd0, 32'h09);
        idle(1);
        check("lat_no_early_start", obs_start, 1'b0);
        idle(1);
        check("lat_start", obs_start, 1'b1);
        check("lat_txd", obs_txd, 32'h09);
        idle(22);
        fixed_len = 0;
        rd(2'd2);
        check("after_frame_status", rd_val, 32'h0000_0002);

        // FIFO fill and overflow while busy is held
        sent.delete();
        hold = 1;
        for (int i = 0; i < 6; i++) wr(2'd0, 32'hA1 + i);
        rd(2'd2);
        check("ovf_full", rd_val[2], 1'b1);
        check("ovf_flag", rd_val[5], 1'b1);
        check("ovf_count", rd_val[15:8], 32'd4);
        hold = 0;
        done_cyc = cyc + 2;
        idle(80);
        check("drain_len", sent.size(), 32'd5);
        for (int i = 0; i < 5 && i < sent.size(); i++) check("drain_order", sent[i], 32'hA1 + i);
        wr(2'd3, 32'h4);

        // RX capture and read
        rxp(8'h09, 0);
        rd(2'd2);
        check("rx_full_set", rd_val[0], 1'b1);
        rd(2'd1);
        check("rx_read", rd_val, 32'h09);
        rd(2'd2);
        check("rx_full_clr", rd_val[0], 1'b0);

        // Overrun, then read in the same cycle as the second byte
        rxp(8'h55, 0);
        rxp(8'h66, 0);
        rd(2'd2);
        check("overrun_set", rd_val[4], 1'b1);
        rd(2'd1);
        check("overrun_keep_old", rd_val, 32'h55);
        wr(2'd3, 32'h4);
        rxp(8'h55, 1);
        step(0, 1, 2'd1, 32'h0, 1, 8'h66, 0);
        check("simul_read_old", rd_val, 32'h55);
        rd(2'd2);
        check("simul_no_overrun", rd_val[4], 1'b0);
        check("simul_full", rd_val[0], 1'b1);
        check("simul_perr_new", rd_val[6], 1'b0);
        rd(2'd1);
        check("simul_new_byte", rd_val, 32'h66);

        // CTRL parity, flag clear, reset mid-frame
        wr(2'd3, 32'h3);
        check("par_en_out", tx_parity_en, 1'b1);
        check("par_odd_out", tx_parity_odd, 1'b1);
        rxp(8'h11, 0);
        rxp(8'h22, 0);
        hold = 1;
        for (int i = 0; i < 6; i++) wr(2'd0, 32'hB0 + i);
        rd(2'd2);
        check("flags_set", rd_val[5:4], 32'h3);
        wr(2'd3, 32'h7);
        rd(2'd2);
        check("flags_clr", rd_val[5:4], 32'h0);
        rd(2'd3);
        check("ctrl_no_bit2", rd_val, 32'h3);
        hold = 0;
        done_cyc = cyc + 2;
        idle(60);
        hold = 1;
        for (int i = 0; i < 3; i++) wr(2'd0, 32'hC0 + i);
        idle(3);
        rd(2'd2);
        check("pre_rst_count", rd_val[15:8], 32'd2);
        check("pre_rst_active", rd_val[3], 1'b1);
        step(0, 0, 2'd0, 32'h0, 0, 8'h00, 0, 1);
        hold = 0;
        rd(2'd2);
        check("post_rst_status", rd_val, 32'h0000_0002);
        rd(2'd3);
        check("post_rst_ctrl", rd_val, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            op = $urandom_range(0, 9);
            wd = $urandom();
            if ($urandom_range(0, 3) != 0) wd[2] = 1'b0;
            case (op)
                0, 1, 2: step(1, 0, 2'd0, wd, $urandom_range(0, 5) == 0, 8'($urandom()), 1'($urandom()),
                              $urandom_range(0, 499) == 0);
                3, 4:    step(0, 1, 2'd1, wd, $urandom_range(0, 5) == 0, 8'($urandom()), 1'($urandom()));
                5:       step(0, 1, 2'd2, wd, $urandom_range(0, 5) == 0, 8'($urandom()), 1'($urandom()));
                6:       step(1, 0, 2'd3, wd, $urandom_range(0, 5) == 0, 8'($urandom()), 1'($urandom()));
                7:       step(0, 1, 2'd3, wd, $urandom_range(0, 5) == 0, 8'($urandom()), 1'($urandom()));
                8:       step(1, 0, 2'($urandom_range(1, 2)), wd, $urandom_range(0, 5) == 0,
                              8'($urandom()), 1'($urandom()));
                default: step(0, 0, 2'd0, wd, $urandom_range(0, 5) == 0, 8'($urandom()), 1'($urandom()));
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
Memory-mapped controller between the multicycle RISC-V core's data bus and the UART tx/rx serial cores. It buffers outgoing bytes in a small TX FIFO and sequences the tx core with a start/busy/done handshake. It captures received bytes into a one-deep holding register and exposes status, sticky error flags and parity configuration to software.

Parameters:
TX_FIFO_DEPTH, 4, TX FIFO entries; power of 2, minimum 2.
DATA_W, 32, bus data width.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous reset, active-high.
bus_addr  input  2  word select: 0 TX_DATA(W), 1 RX_DATA(R), 2 STATUS(R), 3 CTRL(R/W).
bus_we  input  1  write strobe, single cycle.
bus_re  input  1  read strobe, single cycle; side effects only on RX_DATA.
bus_wdata  input  DATA_W  write data.
bus_rdata  output  DATA_W  read data, combinational from bus_addr.
tx_data  output  8  byte presented to the tx core.
tx_start  output  1  one-cycle start pulse to the tx core.
tx_parity_en  output  1  CTRL[0] to the tx core.
tx_parity_odd  output  1  CTRL[1] to the tx core.
tx_busy  input  1  tx core is shifting a frame.
tx_done  input  1  one-cycle pulse at the end of a frame's stop bit.
rx_data  input  8  received byte.
rx_valid  input  1  one-cycle pulse when rx_data is valid.
rx_parity_err  input  1  parity error qualifier, valid with rx_valid.

Behaviour:
- Reset: FSM IDLE; FIFO empty; tx_start=0; tx_data=0; rx_hold=0; rx_full=0; all sticky flags 0; CTRL=0; bus_rdata reflects the reset state.
- STATUS bits:
  - [0] rx_full
  - [1] tx_empty
  - [2] tx_full
  - [3] tx_active (FSM≠IDLE)
  - [4] rx_overrun
  - [5] tx_overflow
  - [6] rx_perr (latched with the byte)
  - [15:8] FIFO count
  - all other bits 0.
- RX_DATA read returns {24'b0, rx_hold}. CTRL read returns {30'b0, parity_odd, parity_en}.
- TX_DATA write: pushes bus_wdata[7:0] when count<DEPTH, or when a pop occurs the same cycle. Otherwise the byte is dropped and tx_overflow is set.
- CTRL write: bits[1:0] update parity. Writing bit[2]=1 clears rx_overrun and tx_overflow; bit[2] is self-clearing and not stored.
- TX FSM:
  - IDLE: if FIFO non-empty, go to LOAD.
  - LOAD (1 cycle): tx_data <= head; tx_start=1; pop; go to WAIT_BUSY.
  - WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: stay until tx_done=1, then go to IDLE.
- TX latency: write at edge N, IDLE sees non-empty in cycle N+1, tx_start is high in cycle N+2. Back-to-back frames are separated by one IDLE cycle after tx_done.
- tx_data holds its value until the next LOAD.
- tx_done in WAIT_BUSY is treated as busy+done in one step: go directly to IDLE.
- RX capture on rx_valid:
  - If rx_full=0: rx_hold <= rx_data; rx_perr <= rx_parity_err; rx_full <= 1.
  - If rx_full=1 and no RX_DATA read this cycle: byte discarded, rx_hold unchanged, rx_overrun set.
- RX_DATA read (bus_re & addr==1) clears rx_full at the edge.
- Simultaneous RX_DATA read and rx_valid: the new byte is loaded, rx_full stays 1, no overrun. The read returns the old byte.
- FIFO pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1.
- Reset mid-frame: the FSM returns to IDLE and the FIFO is flushed. The frame in flight inside the tx core is not aborted by this block.
- Reads and writes to an address with no such access (e.g. a write to STATUS) have no effect.

Optional Feature:
UART_IRQ_EN:
- Defined:
  - Adds output port irq (1 bit) and CTRL bits [3] rx_ie and [4] tx_ie, stored and readable.
  - irq is registered: irq <= (rx_full & rx_ie) | (tx_empty & ~tx_active & tx_ie). It resets to 0.
- Undefined:
  - No irq port.
  - CTRL[4:3] read 0 and writes to them are ignored.

Test Plan:
1. Reset, then read STATUS -> 0x0000_0002 (tx_empty only); tx_start stays 0.
2. Write TX_DATA=0x09 at edge N -> tx_start=1 with tx_data=0x09 in cycle N+2. Model busy 20 cycles then tx_done -> FSM IDLE, STATUS=0x0000_0002.
3. Hold tx_busy=1 and write 0xA1,0xA2,0xA3,0xA4,0xA5,0xA6 -> first byte popped, next 4 fill the FIFO, 6th dropped: STATUS[2]=1, STATUS[5]=1, count=4. Drain -> bytes transmitted in order A1..A5.
4. Pulse rx_valid with rx_data=0x09, rx_parity_err=0 -> STATUS[0]=1. Read RX_DATA -> 0x0000_0009, then STATUS[0]=0.
5. rx_valid 0x55, then rx_valid 0x66 without a read -> rx_overrun=1 and RX_DATA read returns 0x55. Same sequence with a read in the cycle of the 2nd pulse -> read returns 0x55, rx_hold=0x66, rx_overrun=0.
6. Write CTRL=0x3 -> tx_parity_en=1, tx_parity_odd=1. Write CTRL=0x7 with flags set -> STATUS[5:4]=0 and CTRL reads 0x3. Assert rst during WAIT_DONE with 2 bytes queued -> FIFO empty, FSM IDLE, CTRL=0 on the next cycle.
